// File: rtl/rv32_mod_data_bus_bridge.sv
// Single-outstanding LSU-to-Wishbone data bridge with fully registered outputs.
// Defining RV32_DBUS_TIMEOUT_EN adds a bus-wait timeout of TIMEOUT_CYCLES BUS cycles.
module rv32_mod_data_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_data_i,
  output logic [31:0] data_data_o,
  output logic        data_ack,
  output logic        data_err,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack,
  input  logic        wb_err
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t      state, state_nxt;
  logic        cyc_nxt, we_nxt, ack_nxt, err_nxt;
  logic [3:0]  sel_nxt;
  logic [31:0] adr_nxt, wdat_nxt, rdat_nxt;

  // Empty marker block: elaborates only for an illegal TIMEOUT_CYCLES value.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_cycles_out_of_range
  end

`ifdef RV32_DBUS_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt, tmo_cnt_nxt;
`endif

  always_comb begin
    state_nxt = state;
    cyc_nxt   = wb_cyc;
    we_nxt    = wb_we;
    sel_nxt   = wb_sel;
    adr_nxt   = wb_adr;
    wdat_nxt  = wb_dat_o;
    rdat_nxt  = data_data_o;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
`ifdef RV32_DBUS_TIMEOUT_EN
    tmo_cnt_nxt = tmo_cnt;
`endif
    case (state)
      IDLE: begin
        if (data_req) begin
          if (data_be != '0) begin
            state_nxt = BUS;
            cyc_nxt   = 1'b1;
            we_nxt    = data_wr;
            sel_nxt   = data_be;
            adr_nxt   = data_addr;
            wdat_nxt  = data_data_i;
`ifdef RV32_DBUS_TIMEOUT_EN
            tmo_cnt_nxt = '0;
`endif
          end else begin
            state_nxt = RESP;
            err_nxt   = 1'b1;
          end
        end
      end
      BUS: begin
        // wb_err is tested first so it wins over a simultaneous wb_ack
        if (wb_err) begin
          state_nxt = RESP;
          cyc_nxt   = 1'b0;
          err_nxt   = 1'b1;
        end else if (wb_ack) begin
          state_nxt = RESP;
          cyc_nxt   = 1'b0;
          ack_nxt   = 1'b1;
          if (!wb_we) rdat_nxt = wb_dat_i;
        end
`ifdef RV32_DBUS_TIMEOUT_EN
        else if (tmo_cnt == TMO_LAST) begin
          state_nxt = RESP;
          cyc_nxt   = 1'b0;
          err_nxt   = 1'b1;
        end else begin
          tmo_cnt_nxt = tmo_cnt + 16'd1;
        end
`endif
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wb_cyc      <= 1'b0;
      wb_stb      <= 1'b0;
      wb_we       <= 1'b0;
      wb_sel      <= '0;
      wb_adr      <= '0;
      wb_dat_o    <= '0;
      data_data_o <= '0;
      data_ack    <= 1'b0;
      data_err    <= 1'b0;
    end else begin
      state       <= state_nxt;
      wb_cyc      <= cyc_nxt;
      wb_stb      <= cyc_nxt;
      wb_we       <= we_nxt;
      wb_sel      <= sel_nxt;
      wb_adr      <= adr_nxt;
      wb_dat_o    <= wdat_nxt;
      data_data_o <= rdat_nxt;
      data_ack    <= ack_nxt;
      data_err    <= err_nxt;
    end
  end

`ifdef RV32_DBUS_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo_cnt <= '0;
    else       tmo_cnt <= tmo_cnt_nxt;
  end
`endif

endmodule

// File: tb/tb_rv32_mod_data_bus_bridge.sv
// Directed scoreboard bench for rv32_mod_data_bus_bridge (default and RV32_DBUS_TIMEOUT_EN builds).
module tb_rv32_mod_data_bus_bridge;

`ifdef RV32_DBUS_TIMEOUT_EN
  localparam int unsigned TB_TMO = 4;
`else
  localparam int unsigned TB_TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        data_req, data_wr;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_data_i, data_data_o;
  logic        data_ack, data_err;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic        wb_ack, wb_err;

  typedef struct packed {
    logic        ack;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] last_load = '0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  rv32_mod_data_bus_bridge #(.TIMEOUT_CYCLES(TB_TMO)) dut (
    .clk(clk), .reset(reset),
    .data_req(data_req), .data_wr(data_wr), .data_be(data_be),
    .data_addr(data_addr), .data_data_i(data_data_i), .data_data_o(data_data_o),
    .data_ack(data_ack), .data_err(data_err),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
    .wb_adr(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack(wb_ack), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_held(input string tag, input logic wr, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata);
    check({tag, " cyc"}, 32'(wb_cyc), 32'd1);
    check({tag, " stb"}, 32'(wb_stb), 32'd1);
    check({tag, " we"},  32'(wb_we),  32'(wr));
    check({tag, " sel"}, 32'(wb_sel), 32'(be));
    check({tag, " adr"}, wb_adr, addr);
    check({tag, " dat"}, wb_dat_o, wdata);
  endtask

  // One LSU request; bus is terminated with ack/err after `delay` extra BUS cycles
  // (ack=err=0 leaves the bus unterminated).
  task automatic txn(input string tag, input logic wr, input logic [3:0] be,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int unsigned delay, input logic ack, input logic err,
                     input logic [31:0] rdat, input logic perturb);
    exp_t        e, got_e;
    int unsigned lat = 0;
    bit          got = 0;
    e.ack = (be != 4'h0) && ack && !err;
    e.err = !e.ack;
    if (e.ack && !wr) last_load = rdat;
    e.rdata = last_load;
    exp_q.push_back(e);

    data_req = 1'b1; data_wr = wr; data_be = be; data_addr = addr; data_data_i = wdata;
    if (be != 4'h0) begin
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk); lat++; got = wb_cyc;
      end
      check({tag, " strobe latency"}, 32'(lat), 32'd1);
      check_held({tag, " start"}, wr, be, addr, wdata);
      if (perturb) begin
        data_wr = ~wr; data_be = ~be; data_addr = ~addr; data_data_i = ~wdata;
      end
      repeat (delay) begin
        @(negedge clk); lat++;
        check_held({tag, " wait"}, wr, be, addr, wdata);
      end
      wb_ack = ack; wb_err = err; wb_dat_i = rdat;
    end
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk); lat++;
      wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = $urandom;
      if (be == 4'h0) check({tag, " no bus"}, 32'(wb_cyc | wb_stb), 32'd0);
      got = data_ack | data_err;
    end
    check({tag, " resp latency"}, 32'(lat), (be == 4'h0) ? 32'd1 : 32'(2 + delay));
    if (exp_q.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      got_e = exp_q.pop_front();
      check({tag, " data_ack"}, 32'(data_ack), 32'(got_e.ack));
      check({tag, " data_err"}, 32'(data_err), 32'(got_e.err));
      check({tag, " data_data_o"}, data_data_o, got_e.rdata);
    end
    check({tag, " cyc dropped"}, 32'(wb_cyc | wb_stb), 32'd0);
    data_req = 1'b0;
    @(negedge clk);
    check({tag, " single pulse"}, 32'(data_ack | data_err), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    data_req = 1'b0; data_wr = 1'b0; data_be = '0; data_addr = '0; data_data_i = '0;
    wb_dat_i = '0; wb_ack = 1'b0; wb_err = 1'b0;
    repeat (3) @(negedge clk);
    check("reset cyc/stb", 32'({wb_cyc, wb_stb}), 32'd0);
    check("reset ack/err/we", 32'({data_ack, data_err, wb_we}), 32'd0);
    check("reset sel", 32'(wb_sel), 32'd0);
    check("reset adr", wb_adr, 32'd0);
    check("reset dat_o", wb_dat_o, 32'd0);
    check("reset data_data_o", data_data_o, 32'd0);
    reset = 1'b0;

    // Bus terminations while idle must be ignored
    wb_ack = 1'b1; wb_err = 1'b1; wb_dat_i = 32'h5555_AAAA;
    @(negedge clk);
    wb_ack = 1'b0; wb_err = 1'b0;
    @(negedge clk);
    check("idle term ignored", 32'({wb_cyc, data_ack, data_err}), 32'd0);
    check("idle term data", data_data_o, 32'd0);

    txn("load",      1'b0, 4'hF, 32'h0000_1000, 32'h0,          3, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
    txn("fast load", 1'b0, 4'h3, 32'h0000_0044, 32'h0,          0, 1'b1, 1'b0, 32'h1234_5678, 1'b0);
    txn("store",     1'b1, 4'h4, 32'h0000_0020, 32'h00AB_0000,  2, 1'b1, 1'b0, 32'hFFFF_0000, 1'b1);
    txn("ack+err",   1'b0, 4'hF, 32'h0000_0030, 32'h0,          1, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0);
    txn("be zero",   1'b0, 4'h0, 32'h0000_0040, 32'h0,          0, 1'b0, 1'b0, 32'h0,         1'b0);
    txn("store err", 1'b1, 4'hC, 32'h0000_0060, 32'h7777_8888,  0, 1'b0, 1'b1, 32'h9999_9999, 1'b0);
`ifdef RV32_DBUS_TIMEOUT_EN
    txn("timeout",   1'b0, 4'hF, 32'h0000_0050, 32'h0, TB_TMO - 1, 1'b0, 1'b0, 32'h1111_1111, 1'b0);
`else
    txn("long wait", 1'b0, 4'hF, 32'h0000_0050, 32'h0,         12, 1'b1, 1'b0, 32'h0BAD_CAFE, 1'b0);
`endif

    // Reset in the middle of a bus cycle, request held across it
    data_req = 1'b1; data_wr = 1'b0; data_be = 4'hF; data_addr = 32'h0000_0070;
    for (int i = 0; i < 10 && !wb_cyc; i++) @(negedge clk);
    check("pre-reset cyc", 32'(wb_cyc), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid-bus reset cyc/stb", 32'({wb_cyc, wb_stb}), 32'd0);
    check("mid-bus reset no ack", 32'({data_ack, data_err}), 32'd0);
    check("mid-bus reset data", data_data_o, 32'd0);
    last_load = '0;
    @(negedge clk);
    reset = 1'b0;
    txn("reissue",   1'b0, 4'hF, 32'h0000_0070, 32'h0,          1, 1'b1, 1'b0, 32'h0F0F_0F0F, 1'b0);

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
